// File: rtl/rst_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rst_ctrl_pkg
//   Shared types and helpers for the soft reset controller.
//   - soft_rst_state_t : sequencing states of the controller FSM
//   - MIN_PULSE_LEN    : shortest soft_rst pulse ever issued; it must outlast
//                        the one-register delay inside the reset generator
//   - clamp_len()      : maps a requested pulse length onto the pulse that is
//                        actually driven (0 selects the default length)
// -----------------------------------------------------------------------------
package rst_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        RELEASE = 3'd2,
        QUIET   = 3'd3,
        DONE    = 3'd4
    } soft_rst_state_t;

    localparam int unsigned MIN_PULSE_LEN = 2;

    // A zero request means "use the default"; anything shorter than the
    // minimum is stretched so the generator is guaranteed to see the pulse.
    function automatic int unsigned clamp_len(
        input int unsigned req_len,
        input int unsigned def_len
    );
        if (req_len == 0) begin
            return def_len;
        end else if (req_len < MIN_PULSE_LEN) begin
            return MIN_PULSE_LEN;
        end else begin
            return req_len;
        end
    endfunction

endpackage

// File: rtl/soft_rst_ctrl.sv
// -----------------------------------------------------------------------------
// soft_rst_ctrl
//   Issues the soft reset request to the system reset generator and confirms
//   that the generated system reset really went low and came back high.
//   The block runs on the external clk/rst_n only, never on sys_rst_n, so it
//   keeps its state through the reset it requests.
//
//   Ports
//     clk         in   system clock
//     rst_n       in   external reset, asynchronous, active-low
//     req_valid   in   soft reset command valid
//     req_ready   out  command accepted when req_valid && req_ready (IDLE only)
//     req_len     in   soft_rst pulse length in cycles, 0 selects PULSE_LEN_DEF
//     soft_rst    out  registered soft reset request, active-high
//     sys_rst_n   in   generated system reset, fed back for confirmation
//     busy        out  high whenever a sequence is in progress
//     done_valid  out  completion response valid
//     done_ready  in   completion consumed when done_valid && done_ready
//     done_err    out  a timeout occurred during the sequence
//
//   Sequence: IDLE -> ASSERT (pulse) -> RELEASE (wait for sys_rst_n high)
//             -> QUIET (sys_rst_n must stay high QUIET_CYC cycles) -> DONE.
// -----------------------------------------------------------------------------
module soft_rst_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int          LEN_W         = 8,
    parameter int unsigned PULSE_LEN_DEF = 16,
    parameter int unsigned QUIET_CYC     = 8,
    parameter int unsigned TIMEOUT_CYC   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    output logic             soft_rst,
    input  logic             sys_rst_n,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_MAX    = '1;
    localparam logic [LEN_W-1:0] QUIET_LAST = LEN_W'(QUIET_CYC - 1);
    localparam logic [LEN_W-1:0] CNT_ONE    = LEN_W'(1);

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    soft_rst_state_t  r_state;
    soft_rst_state_t  w_state_next;

    // Shared counter: pulse cycles remaining in ASSERT, consecutive
    // high cycles of sys_rst_n in QUIET.
    logic [LEN_W-1:0] r_cnt;
    // Cycles spent in the current state; cleared on every state entry.
    logic [CNT_W-1:0] r_tmo;
    logic             r_seen_low;
    logic             r_err;
    logic             w_err_next;

    logic             r_soft_rst;
    logic             r_req_ready;
    logic             r_busy;
    logic             r_done_valid;
    logic             r_done_err;

    logic             w_soft_rst_next;
    logic             w_req_ready_next;
    logic             w_busy_next;
    logic             w_done_valid_next;
    logic             w_done_err_next;

    // -------------------------------------------------------------------------
    // Decodes
    // -------------------------------------------------------------------------
    logic             w_accept;
    logic             w_seen_now;
    logic             w_pulse_end;
    logic             w_tmo_hit;
    logic             w_quiet_end;
    logic [LEN_W-1:0] w_len_clamped;

    // req_ready is a register that is low straight out of reset, so the
    // handshake is qualified with it rather than with the IDLE decode alone.
    assign w_accept      = (r_state == IDLE) && r_req_ready && req_valid;
    // The generator may already be (or just now be) holding sys_rst_n low.
    assign w_seen_now    = r_seen_low || !sys_rst_n;
    // r_cnt is loaded with the pulse length and reaches 1 on the last
    // programmed cycle; it sits at 0 while ASSERT is being extended.
    assign w_pulse_end   = (r_cnt <= CNT_ONE);
    assign w_tmo_hit     = (r_tmo == TMO_LAST);
    assign w_quiet_end   = sys_rst_n && (r_cnt == QUIET_LAST);
    assign w_len_clamped = LEN_W'(clamp_len(32'(req_len), PULSE_LEN_DEF));

    // -------------------------------------------------------------------------
    // FSM: state register (with registered outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_err        <= 1'b0;
            r_soft_rst   <= 1'b0;
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_err        <= w_err_next;
            r_soft_rst   <= w_soft_rst_next;
            r_req_ready  <= w_req_ready_next;
            r_busy       <= w_busy_next;
            r_done_valid <= w_done_valid_next;
            r_done_err   <= w_done_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = ASSERT;
                    w_err_next   = 1'b0;
                end
            end
            ASSERT: begin
                // Normal exit once the programmed length has elapsed and the
                // generator has responded; otherwise keep the request up
                // until it does or the timeout expires.
                if (w_pulse_end && w_seen_now) begin
                    w_state_next = RELEASE;
                end else if (!w_seen_now && w_tmo_hit) begin
                    w_state_next = RELEASE;
                    w_err_next   = 1'b1;
                end
            end
            RELEASE: begin
                if (sys_rst_n) begin
                    w_state_next = QUIET;
                end else if (w_tmo_hit) begin
                    w_state_next = DONE;
                    w_err_next   = 1'b1;
                end
            end
            QUIET: begin
                if (w_quiet_end) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    w_state_next = IDLE;
                    w_err_next   = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_err_next   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode of the next state, registered above so every output
    // is a flop with no combinational path from the inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        w_soft_rst_next   = (w_state_next == ASSERT);
        w_req_ready_next  = (w_state_next == IDLE);
        w_busy_next       = (w_state_next != IDLE);
        w_done_valid_next = (w_state_next == DONE);
        w_done_err_next   = (w_state_next == DONE) && w_err_next;
    end

    // -------------------------------------------------------------------------
    // Counters and the sys_rst_n low flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_seen_low <= 1'b0;
        end else begin
            // Saturating so very long pulses cannot wrap it back onto the
            // timeout value.
            if (w_state_next != r_state) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_MAX) begin
                r_tmo <= r_tmo + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    r_cnt      <= w_accept ? w_len_clamped : '0;
                    // An external reset already in progress counts as the
                    // generator having responded.
                    r_seen_low <= w_accept && !sys_rst_n;
                end
                ASSERT: begin
                    r_seen_low <= w_seen_now;
                    if (w_state_next != ASSERT) begin
                        r_cnt <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                QUIET: begin
                    r_seen_low <= 1'b0;
                    // Any low cycle restarts the quiet window, so completion
                    // needs QUIET_CYC consecutive high cycles.
                    if (!sys_rst_n || (w_state_next != QUIET)) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_cnt      <= '0;
                    r_seen_low <= 1'b0;
                end
            endcase
        end
    end

    assign soft_rst   = r_soft_rst;
    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign done_valid = r_done_valid;
    assign done_err   = r_done_err;

endmodule

// File: tb/tb_soft_rst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_soft_rst_ctrl
//   Bench for soft_rst_ctrl. A behavioural model tracks which phase of the
//   reset sequence should be active and how long it has lasted; a reset
//   generator model drives sys_rst_n from the model's expected soft_rst with
//   a selectable delay or fault behaviour. Outputs are compared every cycle
//   on the falling edge; directed sequences also pin literal pulse widths,
//   latencies and error flags.
// -----------------------------------------------------------------------------
module tb_soft_rst_ctrl;

    localparam int LEN_W = 8;
    localparam int DEF_LEN = 16;
    localparam int QUIET_N = 8;
    localparam int TMO_N = 64;

    localparam int PH_IDLE  = 0;
    localparam int PH_PULSE = 1;
    localparam int PH_WREL  = 2;
    localparam int PH_QUIET = 3;
    localparam int PH_DONE  = 4;

    localparam int G_LOOP   = 0;
    localparam int G_HIGH   = 1;
    localparam int G_STUCK  = 2;
    localparam int G_PRELOW = 3;
    localparam int G_GLITCH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic [LEN_W-1:0] req_len = '0;
    logic             sys_rst_n = 1'b1;
    logic             done_ready = 1'b0;
    logic             req_ready;
    logic             soft_rst;
    logic             busy;
    logic             done_valid;
    logic             done_err;

    always #5 clk = ~clk;

    soft_rst_ctrl #(
        .LEN_W         (LEN_W),
        .PULSE_LEN_DEF (DEF_LEN),
        .QUIET_CYC     (QUIET_N),
        .TIMEOUT_CYC   (TMO_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_len    (req_len),
        .soft_rst   (soft_rst),
        .sys_rst_n  (sys_rst_n),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_err   (done_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: phase plus time spent in it
    // -------------------------------------------------------------------------
    int m_phase = PH_IDLE;
    int m_el    = 0;     // cycles completed in the current phase
    int m_len   = 0;
    int m_run   = 0;     // consecutive high cycles during the quiet window
    bit m_seen  = 1'b0;
    bit m_err   = 1'b0;
    bit m_rdy_ok = 1'b0; // ready flop has been clocked since reset

    bit hist [4];
    int gen_mode = G_LOOP;
    int gen_delay = 1;
    int gen_mode_seen = G_LOOP;
    bit gen_stuck = 1'b0;
    bit gen_armed = 1'b0;

    logic e_soft, e_ready, e_busy, e_dv, e_de;
    assign e_soft  = (m_phase == PH_PULSE);
    assign e_ready = m_rdy_ok && (m_phase == PH_IDLE);
    assign e_busy  = (m_phase != PH_IDLE);
    assign e_dv    = (m_phase == PH_DONE);
    assign e_de    = (m_phase == PH_DONE) && m_err;

    function automatic int model_len(input int l);
        if (l == 0) return DEF_LEN;
        if (l < 2) return 2;
        return l;
    endfunction

    initial begin
        bit s;
        bit cur_soft;
        bit tap;
        bit v;
        int nph;
        forever begin
            @(posedge clk);
            cur_soft = rst_n && (m_phase == PH_PULSE);
            s = sys_rst_n;
            if (!rst_n) begin
                m_phase = PH_IDLE; m_el = 0; m_err = 1'b0; m_seen = 1'b0;
                m_run = 0; m_rdy_ok = 1'b0;
            end else begin
                nph = m_phase;
                case (m_phase)
                    PH_IDLE: begin
                        if (req_valid && e_ready) begin
                            m_len = model_len(int'(req_len));
                            m_seen = !s;
                            m_err = 1'b0;
                            nph = PH_PULSE;
                        end
                    end
                    PH_PULSE: begin
                        m_seen = m_seen || !s;
                        m_el++;
                        if (m_seen && m_el >= m_len) nph = PH_WREL;
                        else if (!m_seen && m_el >= TMO_N) begin
                            m_err = 1'b1; nph = PH_WREL;
                        end
                    end
                    PH_WREL: begin
                        m_el++;
                        if (s) begin
                            nph = PH_QUIET; m_run = 0;
                        end else if (m_el >= TMO_N) begin
                            m_err = 1'b1; nph = PH_DONE;
                        end
                    end
                    PH_QUIET: begin
                        m_run = s ? m_run + 1 : 0;
                        if (m_run >= QUIET_N) nph = PH_DONE;
                    end
                    default: begin
                        if (done_ready) begin
                            nph = PH_IDLE; m_err = 1'b0;
                        end
                    end
                endcase
                if (nph != m_phase) m_el = 0;
                m_phase = nph;
                m_rdy_ok = 1'b1;
            end

            // Reset generator model fed by the expected soft_rst.
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur_soft;
            if (gen_mode != gen_mode_seen) begin
                gen_stuck = 1'b0; gen_armed = 1'b0; gen_mode_seen = gen_mode;
            end
            tap = hist[gen_delay-1];
            case (gen_mode)
                G_HIGH:  v = 1'b1;
                G_STUCK: begin
                    if (tap) gen_stuck = 1'b1;
                    v = !gen_stuck;
                end
                G_PRELOW: begin
                    if (tap) gen_armed = 1'b1;
                    v = gen_armed ? !tap : 1'b0;
                end
                G_GLITCH: v = !tap && ($urandom_range(0, 7) != 0);
                default: v = !tap;
            endcase
            #1 sys_rst_n = v;
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle compare
    // -------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset soft_rst", soft_rst, 1'b0);
                check("reset req_ready", req_ready, 1'b0);
                check("reset busy", busy, 1'b0);
                check("reset done_valid", done_valid, 1'b0);
                check("reset done_err", done_err, 1'b0);
            end else begin
                check("soft_rst", soft_rst, e_soft);
                check("req_ready", req_ready, e_ready);
                check("busy", busy, e_busy);
                check("done_valid", done_valid, e_dv);
                check("done_err", done_err, e_de);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed sequence: issue one command and measure it from the outputs
    // -------------------------------------------------------------------------
    task automatic wait_model_idle(input string tag, output bit ok);
        int w = 0;
        while (!(m_rdy_ok && m_phase == PH_IDLE) && w < 300) begin
            @(posedge clk); #1; w++;
        end
        ok = (w < 300);
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL %s idle wait: got busy expected idle within 300 cycles", tag);
        end
    endtask

    task automatic run_txn(input string tag, input int len, input int mode, input int dly,
                           input int exp_pulse, input int exp_lat, input bit exp_err,
                           input int hold);
        bit ok;
        bit got;
        int cnt;
        int pulse;
        gen_mode = mode; gen_delay = dly;
        repeat (3) begin @(posedge clk); #1; end
        wait_model_idle(tag, ok);
        if (!ok) return;
        req_len = LEN_W'(len);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cnt = 0; pulse = 0; got = 1'b0;
        while (!got && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (soft_rst) pulse++;
            if (done_valid) got = 1'b1;
        end
        check({tag, " done seen"}, got, 1'b1);
        check_int({tag, " pulse width"}, pulse, exp_pulse);
        if (exp_lat > 0) check_int({tag, " latency"}, cnt, exp_lat);
        check({tag, " done_err"}, done_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check({tag, " hold done_valid"}, done_valid, 1'b1);
            check({tag, " hold done_err"}, done_err, exp_err);
            check({tag, " hold req_ready"}, req_ready, 1'b0);
        end
        req_valid = 1'b0;
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        @(negedge clk);
        check({tag, " idle after done"}, busy, 1'b0);
        $display("txn %s len=%0d mode=%0d delay=%0d pulse=%0d latency=%0d err=%0b",
                 tag, len, mode, dly, pulse, cnt, done_err);
    endtask

    initial begin
        bit ok;
        int r;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready after reset", req_ready, 1'b1);

        // Literal expectations with a one-register generator loopback:
        // latency = len + 2 (release) + QUIET_N + 1 (sampling offset).
        run_txn("len4",    4, G_LOOP,   1,  4, 15, 1'b0, 0);
        run_txn("len0",    0, G_LOOP,   1, 16, 27, 1'b0, 0);
        run_txn("len1",    1, G_LOOP,   1,  2, 13, 1'b0, 0);
        run_txn("latefall",2, G_LOOP,   3,  4, 17, 1'b0, 0);
        run_txn("nofall",  4, G_HIGH,   1, 64, 74, 1'b1, 0);
        run_txn("stuck",   4, G_STUCK,  1,  4, 69, 1'b1, 0);
        run_txn("prelow",  1, G_PRELOW, 3,  2,  0, 1'b0, 0);
        run_txn("hold",    3, G_LOOP,   1,  3, 14, 1'b0, 10);

        // Reset in the middle of the pulse.
        gen_mode = G_LOOP; gen_delay = 1;
        wait_model_idle("midrst", ok);
        if (ok) begin
            req_len = 8'd10; req_valid = 1'b1;
            @(posedge clk); #1 req_valid = 1'b0;
            @(posedge clk); #1;
            check("midrst soft_rst before", soft_rst, 1'b1);
            rst_n = 1'b0;
            #1;
            check("midrst soft_rst async", soft_rst, 1'b0);
            check("midrst busy async", busy, 1'b0);
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("midrst ready after release", req_ready, 1'b1);
            check("midrst no response", done_valid, 1'b0);
            $display("txn midrst reset during pulse, soft_rst=%0b req_ready=%0b", soft_rst, req_ready);
        end

        // Randomised traffic; the per-cycle compare does the checking.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (m_phase == PH_IDLE && $urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 6);
                gen_mode  = (r <= 2) ? G_LOOP : r - 2;
                gen_delay = $urandom_range(1, 3);
            end
            req_valid  = ($urandom_range(0, 3) == 0);
            req_len    = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 255))
                                                     : LEN_W'($urandom_range(0, 12));
            done_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end
        req_valid = 1'b0;
        done_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
